// File: rtl/event_counter_if.sv
// event_counter_if
//   Bundles the rung inputs, configuration and status outputs of one PLC
//   up/down event counter.
//   master modport: instruction datapath / stimulus side (drives rungs, reads status)
//   slave modport : the counter itself
//   Signals:
//     en, cu, cd, load, ctr_rst : control rungs (levels)
//     ctr_type [TYPE_W]          : 00 CTU, 01 CTD, 10 CTUD, 11 invalid
//                                  ("type" is a reserved word, hence ctr_type)
//     preset   [ACC_W]           : preset value, sampled every clock
//     ACC [ACC_W], DN, OV, UN, ERR : registered status
//   Handshake: there is none; all inputs are levels sampled on every rising
//   clk edge and all outputs are registered and valid every cycle.
interface event_counter_if #(
    parameter int ACC_W  = 8,
    parameter int TYPE_W = 2
);
    logic              en;
    logic              cu;
    logic              cd;
    logic              load;
    logic              ctr_rst;
    logic [TYPE_W-1:0] ctr_type;
    logic [ACC_W-1:0]  preset;
    logic [ACC_W-1:0]  ACC;
    logic              DN;
    logic              OV;
    logic              UN;
    logic              ERR;

    modport master (
        output en, cu, cd, load, ctr_rst, ctr_type, preset,
        input  ACC, DN, OV, UN, ERR
    );

    modport slave (
        input  en, cu, cd, load, ctr_rst, ctr_type, preset,
        output ACC, DN, OV, UN, ERR
    );
endinterface

// File: rtl/event_counter.sv
// event_counter
//   PLC up/down event counter (CTU / CTD / CTUD) for the timer/counter bank.
//   Counts rising edges of the cu / cd rungs and reports ACC plus DN/OV/UN/ERR.
//   Ports:
//     clk   : system clock, all state updates on posedge
//     reset : asynchronous, active-high, clears all state
//     bus   : event_counter_if.slave (rungs, type, preset in; status out)
//   Build option:
//     COUNTER_SATURATE_EN - when defined, increment at all-ones holds
//     all-ones and decrement at zero holds zero (OV/UN still set).
//     When undefined, the accumulator wraps.
module event_counter #(
    parameter int ACC_W  = 8,
    parameter int TYPE_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    event_counter_if.slave  bus
);

    localparam logic [TYPE_W-1:0] TYPE_CTU  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_CTD  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_CTUD = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_BAD  = TYPE_W'(3);
    localparam logic [ACC_W-1:0]  ALL_ONES  = {ACC_W{1'b1}};

`ifdef COUNTER_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    logic              cu_q, cu_d;
    logic              cd_q, cd_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              dn_q, dn_d;
    logic              ov_q, ov_d;
    logic              un_q, un_d;
    logic              err_q, err_d;

    logic up_evt;
    logic dn_evt;
    logic type_chg;
    logic do_inc;
    logic do_dec;

    always_comb begin
        // Edge history tracks the rungs even while disabled, so raising en
        // under an already-high rung does not look like a fresh edge.
        cu_d     = bus.cu;
        cd_d     = bus.cd;
        type_d   = bus.ctr_type;

        up_evt   = bus.en & bus.cu & ~cu_q;
        dn_evt   = bus.en & bus.cd & ~cd_q;
        type_chg = (bus.ctr_type != type_q);

        do_inc   = ((bus.ctr_type == TYPE_CTU)  & up_evt) |
                   ((bus.ctr_type == TYPE_CTUD) & up_evt & ~dn_evt);
        do_dec   = ((bus.ctr_type == TYPE_CTD)  & dn_evt) |
                   ((bus.ctr_type == TYPE_CTUD) & dn_evt & ~up_evt);

        acc_d    = acc_q;
        ov_d     = ov_q;
        un_d     = un_q;
        dn_d     = 1'b0;
        err_d    = 1'b0;

        if (bus.ctr_type == TYPE_BAD) begin
            // Invalid type freezes the counter, including across the type
            // change into it; only leaving the invalid type clears.
            err_d = 1'b1;
        end else begin
            if (bus.ctr_rst || type_chg) begin
                acc_d = '0;
                ov_d  = 1'b0;
                un_d  = 1'b0;
            end else if (bus.load && (bus.ctr_type != TYPE_CTU)) begin
                // Load swallows any event arriving in the same cycle.
                acc_d = bus.preset;
            end else if (do_inc) begin
                if (acc_q == ALL_ONES) begin
                    ov_d  = 1'b1;
                    acc_d = SATURATE ? ALL_ONES : '0;
                end else begin
                    acc_d = acc_q + ACC_W'(1);
                end
            end else if (do_dec) begin
                if (acc_q == '0) begin
                    un_d  = 1'b1;
                    acc_d = SATURATE ? '0 : ALL_ONES;
                end else begin
                    acc_d = acc_q - ACC_W'(1);
                end
            end

            // DN follows the next accumulator value so it is always
            // consistent with ACC in the same cycle.
            if (bus.ctr_type == TYPE_CTD) begin
                dn_d = (acc_d == '0);
            end else begin
                dn_d = (acc_d >= bus.preset);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cu_q   <= 1'b0;
            cd_q   <= 1'b0;
            type_q <= TYPE_CTU;
            acc_q  <= '0;
            dn_q   <= 1'b0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cu_q   <= cu_d;
            cd_q   <= cd_d;
            type_q <= type_d;
            acc_q  <= acc_d;
            dn_q   <= dn_d;
            ov_q   <= ov_d;
            un_q   <= un_d;
            err_q  <= err_d;
        end
    end

    assign bus.ACC = acc_q;
    assign bus.DN  = dn_q;
    assign bus.OV  = ov_q;
    assign bus.UN  = un_q;
    assign bus.ERR = err_q;

endmodule

// File: tb/tb_event_counter.sv
// tb_event_counter
//   Directed bench for event_counter: CTU, CTD, CTUD, enable gating,
//   overflow, type handling, preset-driven DN and asynchronous reset.
//   Expected values are hand-computed; COUNTER_SATURATE_EN selects the
//   saturating expectations.
module tb_event_counter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    event_counter_if #(.ACC_W(8), .TYPE_W(2)) bus ();

    event_counter #(.ACC_W(8), .TYPE_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COUNTER_SATURATE_EN
    localparam logic [7:0] CTD_WRAP_ACC = 8'h00;
    localparam logic       CTD_WRAP_DN  = 1'b1;
    localparam logic [7:0] OVF_ACC      = 8'hFF;
    localparam logic       OVF_DN       = 1'b1;
    localparam logic [7:0] OVF_5_ACC    = 8'hFF;
`else
    localparam logic [7:0] CTD_WRAP_ACC = 8'hFF;
    localparam logic       CTD_WRAP_DN  = 1'b0;
    localparam logic [7:0] OVF_ACC      = 8'h00;
    localparam logic       OVF_DN       = 1'b0;
    localparam logic [7:0] OVF_5_ACC    = 8'h05;
`endif

    // Inputs change 1 time unit after the active edge; outputs are read there.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cu;
        bus.cu = 1'b1;
        tick();
        bus.cu = 1'b0;
        tick();
    endtask

    task automatic pulse_cd;
        bus.cd = 1'b1;
        tick();
        bus.cd = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.cu      = 1'b0;
        bus.cd      = 1'b0;
        bus.load    = 1'b0;
        bus.ctr_rst = 1'b0;
        bus.ctr_type = 2'b00;
        bus.preset  = 8'd0;
        tick();
        tick();
        if ({bus.ACC, bus.DN, bus.OV, bus.UN, bus.ERR} !== 12'h000) begin
            $display("FAIL reset_state: got ACC=%0h DN=%0b OV=%0b UN=%0b ERR=%0b want all zero",
                     bus.ACC, bus.DN, bus.OV, bus.UN, bus.ERR);
            n_err++;
        end
        n_vec++;
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic test_ctu;
        bus.ctr_type = 2'b00;
        bus.preset   = 8'd3;
        bus.en       = 1'b1;
        tick();
        bus.cu = 1'b1;
        tick();
        if ({bus.ACC, bus.DN} !== {8'd1, 1'b0}) begin
            $display("FAIL ctu_first: got ACC=%0d DN=%0b want ACC=1 DN=0", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        bus.cu = 1'b0;
        tick();
        pulse_cu();
        if ({bus.ACC, bus.DN} !== {8'd2, 1'b0}) begin
            $display("FAIL ctu_second: got ACC=%0d DN=%0b want ACC=2 DN=0", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        pulse_cu();
        if ({bus.ACC, bus.DN} !== {8'd3, 1'b1}) begin
            $display("FAIL ctu_third: got ACC=%0d DN=%0b want ACC=3 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        bus.cu = 1'b1;
        repeat (10) tick();
        bus.cu = 1'b0;
        tick();
        if (bus.ACC !== 8'd4) begin
            $display("FAIL ctu_held: got ACC=%0d want 4", bus.ACC);
            n_err++;
        end
        n_vec++;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        if (bus.ACC !== 8'd4) begin
            $display("FAIL ctu_load_ignored: got ACC=%0d want 4", bus.ACC);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_ctd;
        bus.ctr_type = 2'b01;
        bus.preset   = 8'd2;
        tick();
        if ({bus.ACC, bus.DN} !== {8'd0, 1'b1}) begin
            $display("FAIL ctd_type_clear: got ACC=%0d DN=%0b want ACC=0 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        if ({bus.ACC, bus.DN} !== {8'd2, 1'b0}) begin
            $display("FAIL ctd_load: got ACC=%0d DN=%0b want ACC=2 DN=0", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        pulse_cd();
        pulse_cd();
        if ({bus.ACC, bus.DN, bus.UN} !== {8'd0, 1'b1, 1'b0}) begin
            $display("FAIL ctd_zero: got ACC=%0d DN=%0b UN=%0b want ACC=0 DN=1 UN=0",
                     bus.ACC, bus.DN, bus.UN);
            n_err++;
        end
        n_vec++;
        pulse_cd();
        if ({bus.ACC, bus.DN, bus.UN} !== {CTD_WRAP_ACC, CTD_WRAP_DN, 1'b1}) begin
            $display("FAIL ctd_underflow: got ACC=%0h DN=%0b UN=%0b want ACC=%0h DN=%0b UN=1",
                     bus.ACC, bus.DN, bus.UN, CTD_WRAP_ACC, CTD_WRAP_DN);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_ctud;
        bus.ctr_type = 2'b10;
        bus.preset   = 8'd5;
        tick();
        if ({bus.ACC, bus.UN} !== {8'd0, 1'b0}) begin
            $display("FAIL ctud_type_clear: got ACC=%0d UN=%0b want ACC=0 UN=0", bus.ACC, bus.UN);
            n_err++;
        end
        n_vec++;
        // load and a cu rising edge together: load wins, edge is lost
        bus.load = 1'b1;
        bus.cu   = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.cu   = 1'b0;
        if ({bus.ACC, bus.DN} !== {8'd5, 1'b1}) begin
            $display("FAIL ctud_load_wins: got ACC=%0d DN=%0b want ACC=5 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        tick();
        bus.preset = 8'd4;
        bus.cu     = 1'b1;
        bus.cd     = 1'b1;
        tick();
        bus.cu = 1'b0;
        bus.cd = 1'b0;
        if (bus.ACC !== 8'd5) begin
            $display("FAIL ctud_both: got ACC=%0d want 5", bus.ACC);
            n_err++;
        end
        n_vec++;
        tick();
        pulse_cu();
        if ({bus.ACC, bus.DN} !== {8'd6, 1'b1}) begin
            $display("FAIL ctud_up: got ACC=%0d DN=%0b want ACC=6 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        pulse_cd();
        if (bus.ACC !== 8'd5) begin
            $display("FAIL ctud_down: got ACC=%0d want 5", bus.ACC);
            n_err++;
        end
        n_vec++;
        bus.ctr_rst = 1'b1;
        tick();
        bus.ctr_rst = 1'b0;
        if ({bus.ACC, bus.OV, bus.UN, bus.DN} !== {8'd0, 3'b000}) begin
            $display("FAIL ctud_ctr_rst: got ACC=%0d OV=%0b UN=%0b DN=%0b want all zero",
                     bus.ACC, bus.OV, bus.UN, bus.DN);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_enable;
        bus.en = 1'b0;
        pulse_cu();
        pulse_cu();
        if (bus.ACC !== 8'd0) begin
            $display("FAIL en_gated: got ACC=%0d want 0", bus.ACC);
            n_err++;
        end
        n_vec++;
        bus.cu = 1'b1;
        tick();
        bus.en = 1'b1;
        tick();
        tick();
        if (bus.ACC !== 8'd0) begin
            $display("FAIL en_raise_under_cu: got ACC=%0d want 0", bus.ACC);
            n_err++;
        end
        n_vec++;
        bus.cu = 1'b0;
        tick();
        pulse_cu();
        if (bus.ACC !== 8'd1) begin
            $display("FAIL en_next_edge: got ACC=%0d want 1", bus.ACC);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_overflow;
        bus.ctr_type = 2'b00;
        bus.preset   = 8'd3;
        tick();
        for (int i = 0; i < 255; i++) pulse_cu();
        if ({bus.ACC, bus.OV, bus.DN} !== {8'hFF, 1'b0, 1'b1}) begin
            $display("FAIL ovf_pre: got ACC=%0h OV=%0b DN=%0b want ACC=ff OV=0 DN=1",
                     bus.ACC, bus.OV, bus.DN);
            n_err++;
        end
        n_vec++;
        pulse_cu();
        if ({bus.ACC, bus.OV, bus.DN} !== {OVF_ACC, 1'b1, OVF_DN}) begin
            $display("FAIL ovf_wrap: got ACC=%0h OV=%0b DN=%0b want ACC=%0h OV=1 DN=%0b",
                     bus.ACC, bus.OV, bus.DN, OVF_ACC, OVF_DN);
            n_err++;
        end
        n_vec++;
        for (int i = 0; i < 5; i++) pulse_cu();
        if ({bus.ACC, bus.OV} !== {OVF_5_ACC, 1'b1}) begin
            $display("FAIL ovf_sticky: got ACC=%0h OV=%0b want ACC=%0h OV=1",
                     bus.ACC, bus.OV, OVF_5_ACC);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_type;
        bus.ctr_type = 2'b11;
        tick();
        if ({bus.ERR, bus.DN, bus.ACC, bus.OV} !== {1'b1, 1'b0, OVF_5_ACC, 1'b1}) begin
            $display("FAIL type_invalid: got ERR=%0b DN=%0b ACC=%0h OV=%0b want ERR=1 DN=0 ACC=%0h OV=1",
                     bus.ERR, bus.DN, bus.ACC, bus.OV, OVF_5_ACC);
            n_err++;
        end
        n_vec++;
        pulse_cu();
        if ({bus.ERR, bus.ACC} !== {1'b1, OVF_5_ACC}) begin
            $display("FAIL type_invalid_hold: got ERR=%0b ACC=%0h want ERR=1 ACC=%0h",
                     bus.ERR, bus.ACC, OVF_5_ACC);
            n_err++;
        end
        n_vec++;
        bus.ctr_type = 2'b00;
        tick();
        if ({bus.ERR, bus.ACC, bus.OV} !== {1'b0, 8'd0, 1'b0}) begin
            $display("FAIL type_leave_invalid: got ERR=%0b ACC=%0h OV=%0b want ERR=0 ACC=0 OV=0",
                     bus.ERR, bus.ACC, bus.OV);
            n_err++;
        end
        n_vec++;
        pulse_cu();
        pulse_cu();
        bus.ctr_type = 2'b10;
        tick();
        if ({bus.ERR, bus.ACC} !== {1'b0, 8'd0}) begin
            $display("FAIL type_ctu_to_ctud: got ERR=%0b ACC=%0d want ERR=0 ACC=0", bus.ERR, bus.ACC);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_preset;
        bus.preset = 8'd0;
        tick();
        if ({bus.ACC, bus.DN} !== {8'd0, 1'b1}) begin
            $display("FAIL preset_zero: got ACC=%0d DN=%0b want ACC=0 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
        bus.preset = 8'd1;
        tick();
        if (bus.DN !== 1'b0) begin
            $display("FAIL preset_one: got DN=%0b want 0", bus.DN);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_async_reset;
        bus.ctr_type = 2'b01;
        bus.preset   = 8'd3;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        pulse_cd();
        #2 reset = 1'b1;
        #1;
        if ({bus.ACC, bus.DN, bus.OV, bus.UN, bus.ERR} !== 12'h000) begin
            $display("FAIL async_reset: got ACC=%0h DN=%0b OV=%0b UN=%0b ERR=%0b want all zero",
                     bus.ACC, bus.DN, bus.OV, bus.UN, bus.ERR);
            n_err++;
        end
        n_vec++;
        #1 reset = 1'b0;
        tick();
        if ({bus.ACC, bus.DN} !== {8'd0, 1'b1}) begin
            $display("FAIL post_reset_ctd: got ACC=%0d DN=%0b want ACC=0 DN=1", bus.ACC, bus.DN);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ctu();
        test_ctd();
        test_ctud();
        test_enable();
        test_overflow();
        test_type();
        test_preset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/event_counter.md
# event_counter

PLC up/down event counter for the IL processor's timer/counter peripheral bank. It is the counting-direction counterpart of the on-delay, off-delay and retentive timers. It counts rising edges on count-up and count-down rungs instead of clock ticks, and exposes the same DN/ACC status style to the instruction datapath. It supports three types, CTU, CTD and CTUD, selected by a type code with the same encoding width as the timers.

## Interface
- ACC_W, 8, accumulator and preset width
- TYPE_W, 2, type code width
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  counter enable; count events are ignored when low
- cu  in  1  count-up rung, level input, rising edge counted
- cd  in  1  count-down rung, level input, rising edge counted
- load  in  1  synchronous load, ACC <= preset
- ctr_rst  in  1  synchronous counter reset (RES instruction)
- type  in  TYPE_W  00 CTU, 01 CTD, 10 CTUD, 11 invalid
- preset  in  ACC_W  preset value, sampled every clock
- ACC  out  ACC_W  accumulator
- DN  out  1  done flag
- OV  out  1  sticky overflow
- UN  out  1  sticky underflow
- ERR  out  1  invalid type selected

## Operation
- Edge detect:
  - cu_q and cd_q register cu and cd every clock, regardless of en.
  - up_evt = en & cu & ~cu_q.
  - dn_evt = en & cd & ~cd_q.
  - Raising en while cu is already high does not count.
- type_q registers type every clock. When type differs from type_q, the cycle acts as ctr_rst.
- Update priority in one clock:
  1. ctr_rst or type change: ACC=0, OV=0, UN=0.
  2. load: ACC=preset (CTD and CTUD only; ignored in CTU).
  3. Events per type.
- CTU: up_evt gives ACC+1. dn_evt is ignored.
- CTD: dn_evt gives ACC-1. up_evt is ignored.
- CTUD: up_evt alone gives +1, dn_evt alone gives -1, both in the same cycle give no change.
- Increment from all-ones wraps to 0 and sets OV. Decrement from 0 wraps to all-ones and sets UN. OV and UN stay set until reset or ctr_rst.
- DN is computed from the next ACC and type:
  - CTU and CTUD: DN = (ACC >= preset), unsigned.
  - CTD: DN = (ACC == 0).
- Invalid type (11): ACC, OV and UN are held; DN=0, ERR=1. Valid types: ERR=0.

## Timing
- Reset values: ACC=0, DN=0, OV=0, UN=0, ERR=0, cu_q=0, cd_q=0, type_q=00.
- One-cycle latency: cu is sampled high at edge N with cu_q low, and ACC, DN and OV reflect the count after edge N. Each rising edge of cu counts once, however long cu stays high.
- ACC, DN, OV, UN and ERR are all registered and always mutually consistent.
- Reset mid-count clears everything asynchronously. The first post-reset edge re-evaluates DN; in CTD with ACC=0 this gives DN=1.
- preset changes take effect on DN at the next clock, without any event.
- load together with an event in the same cycle: load wins and the event is lost.

## Configuration
- COUNTER_SATURATE_EN defined: increment at all-ones holds all-ones, and decrement at 0 holds 0. OV and UN are still set.
- COUNTER_SATURATE_EN undefined: wrap-around as described in Operation.

## Test plan
- CTU counting, preset=3, en=1:
  - Three cu pulses give ACC 1,2,3, with DN=1 after the third.
  - cu held high for 10 clocks adds only 1.
- CTD countdown, preset=2:
  - load gives ACC=2.
  - Two cd pulses give ACC=0 and DN=1.
  - A third cd pulse gives ACC=FF and UN=1 (with saturation: ACC=0, UN=1).
- CTUD, ACC=5:
  - cu and cd rising in the same cycle leave ACC=5.
  - A cu-only pulse gives 6.
  - ctr_rst gives ACC=0, OV=0, UN=0, DN=0 (preset=4).
- Enable gating, en=0:
  - cu pulses leave ACC unchanged.
  - Raising en while cu is high adds nothing.
  - The next cu rising edge adds 1.
- Overflow, CTU, ACC=FF:
  - A cu pulse gives ACC=00 and OV=1 (with saturation: ACC=FF, OV=1).
  - OV stays 1 through 5 more pulses.
- Reset and type handling:
  - Async reset asserted mid-clock clears all outputs immediately.
  - type=11 gives ERR=1 with ACC held.
  - A type change from 00 to 10 clears ACC.
